firebird7_in_gate1_tessent_data_mux_tdr: RTL and testbench
==========================================================

// Module: firebird7_in_gate1_tessent_data_mux_tdr
// PURPOSE
//   Parametrised IJTAG data-override TDR. CHANNELS independent WIDTH-bit data muxes; selects and
//   override data come from an internal scan register with capture/shift/update shadowing.
//   Optional timed mode auto-releases overrides after PULSE_CYCLES. Sits behind a SIB on the
//   gate1 IJTAG network, between functional logic and its consumers.
// PARAMETERS
//   WIDTH         3   data bits per channel (>=1)
//   CHANNELS      4   number of independent mux channels (>=1)
//   TIMED_MODE    0   0: override holds until next update; 1: override auto-clears after PULSE_CYCLES
//   PULSE_CYCLES  16  override duration in ijtag_tck cycles when TIMED_MODE=1 (>=1, elaboration error if 0)
// PORTS
//   ijtag_tck           in   1               test clock, all state on posedge
//   ijtag_reset         in   1               async reset, active-high
//   ijtag_sel           in   1               TDR selected on scan path
//   ijtag_ce            in   1               capture enable
//   ijtag_se            in   1               shift enable
//   ijtag_ue            in   1               update enable
//   ijtag_si            in   1               scan in
//   ijtag_so            out  1               scan out = shift_reg[0]
//   functional_data_in  in   CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   data_out            out  CHANNELS*WIDTH  muxed data, same packing
//   override_active     out  CHANNELS        per-channel shadow select
// BEHAVIOUR
//   - Scan register L = CHANNELS*(WIDTH+1); segment c = {sel_c, data_c[WIDTH-1:0]} at [c*(WIDTH+1) +: WIDTH+1];
//     channel 0 nearest ijtag_so.
//   - Reset: shift_reg=0, shadow selects=0, shadow data=0, counter=0 => data_out=functional_data_in,
//     override_active=0, ijtag_so=0. Reset asserted mid-pulse or mid-shift clears everything immediately.
//   - Gated by ijtag_sel; ijtag_sel=0 => shift_reg, shadows, counter unchanged by ce/se/ue (timer still runs).
//   - Capture (sel&ce): segment c <= {override_active[c], functional_data_in[c]}. Priority ce > se.
//   - Shift (sel&se&!ce): shift_reg <= {ijtag_si, shift_reg[L-1:1]}; one bit per tck.
//   - Update (sel&ue): shadows <= current shift_reg (pre-edge value); independent of ce/se at same edge.
//   - data_out[c] = override_active[c] ? shadow_data[c] : functional_data_in[c]; combinational from
//     registers; override visible in the cycle after the update edge; functional path has 0 latency.
//   - TIMED_MODE=1 counter, width $clog2(PULSE_CYCLES+1):
//       IDLE (cnt=0) --update with any sel bit=1--> RUN (cnt<=PULSE_CYCLES)
//       RUN: cnt decrements each tck; at edge where cnt==1, all shadow selects <=0, cnt<=0 -> IDLE
//       => override lasts exactly PULSE_CYCLES cycles. Update during RUN reloads cnt (retrigger);
//       update with all sel bits=0 clears selects and forces IDLE. Update on the expiry edge wins.
//       Shadow data retained after expiry (only selects clear).
//   - TIMED_MODE=0: counter not generated; selects change only on update or reset.
//   - No X propagation: all flops reset; override_active is a pure register output.
// STRUCTURE
//   - Package firebird7_in_gate1_tessent_data_mux_pkg: typedef chan_seg_t (sel + data struct, WIDTH
//     from param), mode localparams TIMED_OFF/TIMED_ON, function seg_lsb(c) for packing.
//   - One sub-module: firebird7_in_gate1_tessent_data_mux_chan (per-channel combinational mux,
//     WIDTH param), instantiated CHANNELS times via generate.
//   - Scan register, shadows, timer stay in top module.
// TESTING  (CHANNELS=4, WIDTH=3 unless noted)
//   1 Reset: ijtag_reset=1, functional_data_in=12'hA5C -> data_out=12'hA5C, override_active=0, so=0.
//   2 Shift 16 bits of 16'h000F (LSB first) then update -> override_active=4'b0001, ch0 data_out=3'h7,
//     ch1..3 follow functional; so sequence during a second shift returns prior contents bit-exact.
//   3 Capture with ch2 overridden & functional ch2=3'h5, shift out -> bits [11:8] read {1,3'b101}.
//   4 ijtag_sel=0 with ce/se/ue toggling -> shadows, shift_reg, data_out unchanged.
//   5 TIMED_MODE=1, PULSE_CYCLES=5: update ch1 override -> override_active[1]=1 for exactly 5 tck then 0;
//     retrigger at cycle 3 -> holds until cycle 8; update on expiry edge -> stays active.
//   6 Assert ijtag_reset mid-shift and mid-pulse (cycle 2 of 5) -> all outputs to reset values async,
//     counter idle after deassert.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types, mode constants and scan-segment packing helper for the gate1
// data-override TDR.
package firebird7_in_gate1_tessent_data_mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  localparam int unsigned TIMED_OFF = 0;
  localparam int unsigned TIMED_ON  = 1;

  // One scan segment as it appears on the chain: select bit above the data bits.
  typedef struct packed {
    logic                     sel;
    logic [DEFAULT_WIDTH-1:0] data;
  } chan_seg_t;

  function automatic int unsigned seg_lsb(input int unsigned c, input int unsigned width);
    return c * (width + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_chan.sv
// Per-channel override mux: shadow data replaces functional data while the
// channel's shadow select is set.
module firebird7_in_gate1_tessent_data_mux_chan #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] override_data,
  input  logic [WIDTH-1:0] func_data,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = sel ? override_data : func_data;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// IJTAG data-override TDR: capture/shift/update scan register feeding per-channel
// shadow selects and data, with an optional auto-release pulse timer.
module firebird7_in_gate1_tessent_data_mux_tdr
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TIMED_MODE   = TIMED_OFF,
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic                      ijtag_sel,
  input  logic                      ijtag_ce,
  input  logic                      ijtag_se,
  input  logic                      ijtag_ue,
  input  logic                      ijtag_si,
  output logic                      ijtag_so,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       override_active
);

  localparam int unsigned SEG_W    = WIDTH + 1;
  localparam int unsigned SCAN_LEN = CHANNELS * SEG_W;

  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("PULSE_CYCLES must be at least 1");
  end

  logic [SCAN_LEN-1:0]       shift_q, shift_d;
  logic [CHANNELS-1:0]       sel_q, sel_d, scan_sel;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d, scan_data;
  logic                      capture_en, shift_en, update_en, pulse_expire;

  assign capture_en = ijtag_sel & ijtag_ce;
  assign shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign update_en  = ijtag_sel & ijtag_ue;

  always_comb begin
    scan_sel  = '0;
    scan_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      scan_sel[c]                  = shift_q[seg_lsb(c, WIDTH) + WIDTH];
      scan_data[c*WIDTH +: WIDTH]  = shift_q[seg_lsb(c, WIDTH) +: WIDTH];
    end
  end

  // Update samples the pre-edge scan register, so it is independent of a same-edge capture/shift.
  always_comb begin
    shift_d = shift_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (capture_en) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        shift_d[seg_lsb(c, WIDTH) +: SEG_W] = {sel_q[c], functional_data_in[c*WIDTH +: WIDTH]};
      end
    end else if (shift_en) begin
      shift_d = {ijtag_si, shift_q[SCAN_LEN-1:1]};
    end
    if (update_en) begin
      sel_d  = scan_sel;
      data_d = scan_data;
    end else if (pulse_expire) begin
      sel_d = '0;
    end
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      shift_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      shift_q <= shift_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  if (TIMED_MODE == TIMED_ON) begin : g_timer
    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt==0 is idle; a reload on update takes precedence over the expiry edge.
    always_comb begin
      cnt_d = cnt_q;
      if (update_en) begin
        cnt_d = (|scan_sel) ? CNT_W'(PULSE_CYCLES) : '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pulse_expire = (cnt_q == CNT_W'(1));
  end else begin : g_no_timer
    assign pulse_expire = 1'b0;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    firebird7_in_gate1_tessent_data_mux_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .sel          (sel_q[c]),
      .override_data(data_q[c*WIDTH +: WIDTH]),
      .func_data    (functional_data_in[c*WIDTH +: WIDTH]),
      .data_out     (data_out[c*WIDTH +: WIDTH])
    );
  end

  assign ijtag_so        = shift_q[0];
  assign override_active = sel_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Directed bench: an untimed instance and a TIMED_MODE=1/PULSE_CYCLES=5 instance
// share all inputs; expected values are hand-computed constants.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;
  import firebird7_in_gate1_tessent_data_mux_pkg::*;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic [11:0] functional_data_in;
  logic        so_n, so_t;
  logic [11:0] data_out_n, data_out_t;
  logic [3:0]  ovr_n, ovr_t;

  int check_count = 0;
  int error_count = 0;

  firebird7_in_gate1_tessent_data_mux_tdr dut (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .ijtag_sel         (ijtag_sel),
    .ijtag_ce          (ijtag_ce),
    .ijtag_se          (ijtag_se),
    .ijtag_ue          (ijtag_ue),
    .ijtag_si          (ijtag_si),
    .ijtag_so          (so_n),
    .functional_data_in(functional_data_in),
    .data_out          (data_out_n),
    .override_active   (ovr_n)
  );

  firebird7_in_gate1_tessent_data_mux_tdr #(
    .TIMED_MODE  (TIMED_ON),
    .PULSE_CYCLES(5)
  ) dut_t (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .ijtag_sel         (ijtag_sel),
    .ijtag_ce          (ijtag_ce),
    .ijtag_se          (ijtag_se),
    .ijtag_ue          (ijtag_ue),
    .ijtag_si          (ijtag_si),
    .ijtag_so          (so_t),
    .functional_data_in(functional_data_in),
    .data_out          (data_out_t),
    .override_active   (ovr_t)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic applyStimulus(input logic ce, input logic se, input logic ue, input logic si);
    ijtag_ce = ce;
    ijtag_se = se;
    ijtag_ue = ue;
    ijtag_si = si;
    tick();
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
    ijtag_si = 1'b0;
  endtask

  // LSB first in; vout collects ijtag_so before each shifting edge.
  task automatic shiftVector(input logic [15:0] vin, output logic [15:0] vout);
    vout = '0;
    for (int i = 0; i < 16; i++) begin
      vout[i] = so_n;
      applyStimulus(1'b0, 1'b1, 1'b0, vin[i]);
    end
  endtask

  task automatic resetPulse;
    ijtag_reset = 1'b1;
    tick();
    ijtag_reset = 1'b0;
    tick();
  endtask

  logic [15:0] sout;
  chan_seg_t   cap_seg;

  initial begin
    ijtag_reset = 1'b1;
    ijtag_sel = 1'b1;
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
    ijtag_si = 1'b0;
    functional_data_in = 12'hA5C;

    // Reset values
    #2;
    checkOutput("rst_data_out", 32'(data_out_n), 32'h0A5C);
    checkOutput("rst_override", 32'(ovr_n), 32'h0);
    checkOutput("rst_so", 32'(so_n), 32'h0);
    checkOutput("rst_t_override", 32'(ovr_t), 32'h0);
    tick();
    tick();
    ijtag_reset = 1'b0;
    tick();

    // Shift/update ch0 override, then read back the chain contents twice
    shiftVector(16'h000F, sout);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("upd_override", 32'(ovr_n), 32'h1);
    checkOutput("upd_data_out", 32'(data_out_n), 32'h0A5F);
    shiftVector(16'h1234, sout);
    checkOutput("readback_1", 32'(sout), 32'h000F);
    shiftVector(16'h0000, sout);
    checkOutput("readback_2", 32'(sout), 32'h1234);

    // Capture with ch2 overridden
    functional_data_in = 12'h140;
    shiftVector(16'h0A00, sout);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ch2_override", 32'(ovr_n), 32'h4);
    checkOutput("ch2_data_out", 32'(data_out_n), 32'h080);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    shiftVector(16'h0000, sout);
    cap_seg = '{sel: 1'b1, data: 3'h5};
    checkOutput("capture_seg2", 32'(sout[11:8]), 32'(cap_seg));
    checkOutput("capture_all", 32'(sout), 32'h0D00);

    // Deselected: ce/se/ue have no effect
    ijtag_sel = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("nosel_override", 32'(ovr_n), 32'h4);
    checkOutput("nosel_data_out", 32'(data_out_n), 32'h080);
    checkOutput("nosel_so", 32'(so_n), 32'h0);
    ijtag_sel = 1'b1;
    shiftVector(16'h0000, sout);
    checkOutput("nosel_chain", 32'(sout), 32'h0);

    // Capture wins over shift on the same edge
    functional_data_in = 12'h001;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("prio_so", 32'(so_n), 32'h1);
    shiftVector(16'h0000, sout);
    checkOutput("prio_chain", 32'(sout), 32'h0801);

    // Timed pulse: exactly five cycles
    resetPulse();
    functional_data_in = 12'h123;
    shiftVector(16'h0080, sout);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t_pulse_c1", 32'(ovr_t), 32'h2);
    checkOutput("t_pulse_data", 32'(data_out_t), 32'h103);
    for (int cyc = 2; cyc <= 5; cyc++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("t_pulse_c%0d", cyc), 32'(ovr_t), 32'h2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t_pulse_off", 32'(ovr_t), 32'h0);
    checkOutput("t_pulse_off_data", 32'(data_out_t), 32'h123);
    checkOutput("untimed_holds", 32'(ovr_n), 32'h2);

    // Retrigger on cycle 3
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      applyStimulus(1'b0, 1'b0, 1'(cyc == 3), 1'b0);
      checkOutput($sformatf("t_retrig_c%0d", cyc), 32'(ovr_t), (cyc < 8) ? 32'h2 : 32'h0);
    end

    // Update on the expiry edge keeps the override alive
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      applyStimulus(1'b0, 1'b0, 1'(cyc == 5), 1'b0);
      checkOutput($sformatf("t_expupd_c%0d", cyc), 32'(ovr_t), (cyc < 10) ? 32'h2 : 32'h0);
    end

    // Async reset mid-pulse and mid-shift
    shiftVector(16'h0082, sout);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pre_rst_so", 32'(so_n), 32'h1);
    checkOutput("pre_rst_t_override", 32'(ovr_t), 32'h2);
    ijtag_se = 1'b1;
    ijtag_si = 1'b1;
    #2;
    ijtag_reset = 1'b1;
    #1;
    checkOutput("arst_so", 32'(so_n), 32'h0);
    checkOutput("arst_t_so", 32'(so_t), 32'h0);
    checkOutput("arst_override", 32'(ovr_n), 32'h0);
    checkOutput("arst_t_override", 32'(ovr_t), 32'h0);
    checkOutput("arst_data_out", 32'(data_out_n), 32'h123);
    checkOutput("arst_t_data_out", 32'(data_out_t), 32'h123);
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
    tick();
    ijtag_reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("post_rst_t_override", 32'(ovr_t), 32'h0);
    checkOutput("post_rst_so", 32'(so_n), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
